// File: rtl/div_pkg.sv
// Shared definitions for the iterative divider: state encoding, the
// divide-by-zero quotient fill value and the iteration counter width.
package div_pkg;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_FIX  = 2'd2,
    DIV_DONE = 2'd3
  } div_state_e;

  // Every quotient bit is set when the divisor is zero.
  localparam logic DIV_ZERO_Q_FILL = 1'b1;

  // Counter must be able to hold WIDTH itself, hence one bit above clog2.
  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/div_iter_lzc.sv
// Combinational leading-zero counter; returns WIDTH for an all-zero input.
module lzc #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]       data_i,
  output logic [$clog2(WIDTH):0] count_o
);

  localparam int CW = $clog2(WIDTH) + 1;

  // Scan LSB to MSB so the highest set bit has the final say.
  always_comb begin
    count_o = CW'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (data_i[i]) count_o = CW'(WIDTH - 1 - i);
    end
  end

endmodule

// File: rtl/div_iter.sv
// Iterative restoring divider, one quotient bit per cycle, working on operand
// magnitudes and fixing signs in a final cycle.
//
// state    | meaning
// ---------+------------------------------------------------------------
// DIV_IDLE | waiting for a request, req_ready high
// DIV_CALC | one restoring step per cycle until the counter runs out
// DIV_FIX  | apply result signs and load the output registers
// DIV_DONE | response valid, outputs held until resp_ready
module div_iter
  import div_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter bit EARLY_TERM = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  input  logic             cancel,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             div_by_zero_o
);

  localparam int CW = cnt_width(WIDTH);

  div_state_e       state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;     // dividend shifts out, quotient shifts in
  logic [WIDTH-1:0] bmag_q, bmag_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sign_a_q, sign_a_d;
  logic             sign_b_q, sign_b_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] remo_q, remo_d;
  logic             dbz_q, dbz_d;

  logic             accept;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] amag, bmag;
  logic [CW-1:0]    lz;
  logic [CW-1:0]    cnt_init;
  logic [WIDTH:0]   shifted, trial;
  logic             borrow;

  assign req_ready     = (state_q == DIV_IDLE);
  assign resp_valid    = (state_q == DIV_DONE);
  assign quotient_o    = quo_q;
  assign remainder_o   = remo_q;
  assign div_by_zero_o = dbz_q;

  assign accept = req_valid && req_ready && !cancel;
  assign a_neg  = signed_op && dividend_i[WIDTH-1];
  assign b_neg  = signed_op && divisor_i[WIDTH-1];
  assign amag   = a_neg ? -dividend_i : dividend_i;
  assign bmag   = b_neg ? -divisor_i : divisor_i;

  // Leading zeros of |a| only matter when early termination is enabled;
  // otherwise a zero shift gives the full WIDTH iterations.
  if (EARLY_TERM) begin : g_lzc
    lzc #(.WIDTH(WIDTH)) u_lzc (
      .data_i (amag),
      .count_o(lz)
    );
  end else begin : g_no_lzc
    assign lz = '0;
  end

  assign cnt_init = CW'(WIDTH) - lz;

  // Partial remainder is always below |b|, so a negative trial shows up in
  // the top bit of the WIDTH+1 wide difference.
  assign shifted = {rem_q, dvd_q[WIDTH-1]};
  assign trial   = shifted - {1'b0, bmag_q};
  assign borrow  = trial[WIDTH];

  // Next-state, datapath and output-register update.
  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    dvd_d    = dvd_q;
    bmag_d   = bmag_q;
    cnt_d    = cnt_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    quo_d    = quo_q;
    remo_d   = remo_q;
    dbz_d    = dbz_q;

    case (state_q)
      DIV_IDLE: begin
        if (accept) begin
          sign_a_d = a_neg;
          sign_b_d = b_neg;
          if (divisor_i == '0) begin
            quo_d   = {WIDTH{DIV_ZERO_Q_FILL}};
            remo_d  = dividend_i;
            dbz_d   = 1'b1;
            state_d = DIV_DONE;
          end else begin
            rem_d   = '0;
            dvd_d   = amag << lz;
            bmag_d  = bmag;
            cnt_d   = cnt_init;
            state_d = (cnt_init == '0) ? DIV_FIX : DIV_CALC;
          end
        end
      end
      DIV_CALC: begin
        rem_d = borrow ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
        dvd_d = {dvd_q[WIDTH-2:0], ~borrow};
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) state_d = DIV_FIX;
      end
      DIV_FIX: begin
        quo_d   = (sign_a_q ^ sign_b_q) ? -dvd_q : dvd_q;
        remo_d  = sign_a_q ? -rem_q : rem_q;
        dbz_d   = 1'b0;
        state_d = DIV_DONE;
      end
      DIV_DONE: begin
        if (resp_ready) begin
          quo_d   = '0;
          remo_d  = '0;
          dbz_d   = 1'b0;
          state_d = DIV_IDLE;
        end
      end
      default: state_d = DIV_IDLE;
    endcase

    // A flush wins over any accept or response handshake.
    if (cancel) begin
      quo_d   = '0;
      remo_d  = '0;
      dbz_d   = 1'b0;
      state_d = DIV_IDLE;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= DIV_IDLE;
      rem_q    <= '0;
      dvd_q    <= '0;
      bmag_q   <= '0;
      cnt_q    <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      quo_q    <= '0;
      remo_q   <= '0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      dvd_q    <= dvd_d;
      bmag_q   <= bmag_d;
      cnt_q    <= cnt_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      quo_q    <= quo_d;
      remo_q   <= remo_d;
      dbz_q    <= dbz_d;
    end
  end

endmodule

// File: tb/tb_div_iter.sv
// Directed bench for div_iter: 32-bit instances without and with early
// termination, plus a 64-bit instance checked against language division.
module tb_div_iter;

  localparam int LIMIT = 200;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  rv32;
  logic        signed_op;
  logic [31:0] dividend, divisor;
  logic        cancel;
  logic        resp_ready;

  logic        req_ready0, resp_valid0, dz0;
  logic [31:0] q0, r0;
  logic        req_ready1, resp_valid1, dz1;
  logic [31:0] q1, r1;

  logic        rv64, sop64, rr64;
  logic [63:0] a64, b64;
  logic        req_ready64, resp_valid64, dz64;
  logic [63:0] q64, r64;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  div_iter #(.WIDTH(32), .EARLY_TERM(1'b0)) u_dut0 (
    .clk(clk), .rst(rst), .req_valid(rv32[0]), .req_ready(req_ready0),
    .signed_op(signed_op), .dividend_i(dividend), .divisor_i(divisor),
    .cancel(cancel), .resp_valid(resp_valid0), .resp_ready(resp_ready),
    .quotient_o(q0), .remainder_o(r0), .div_by_zero_o(dz0)
  );

  div_iter #(.WIDTH(32), .EARLY_TERM(1'b1)) u_dut1 (
    .clk(clk), .rst(rst), .req_valid(rv32[1]), .req_ready(req_ready1),
    .signed_op(signed_op), .dividend_i(dividend), .divisor_i(divisor),
    .cancel(cancel), .resp_valid(resp_valid1), .resp_ready(resp_ready),
    .quotient_o(q1), .remainder_o(r1), .div_by_zero_o(dz1)
  );

  div_iter #(.WIDTH(64), .EARLY_TERM(1'b1)) u_dut64 (
    .clk(clk), .rst(rst), .req_valid(rv64), .req_ready(req_ready64),
    .signed_op(sop64), .dividend_i(a64), .divisor_i(b64),
    .cancel(cancel), .resp_valid(resp_valid64), .resp_ready(rr64),
    .quotient_o(q64), .remainder_o(r64), .div_by_zero_o(dz64)
  );

  // Issue one request on a 32-bit instance, wait (bounded) for the response,
  // capture it, then complete the handshake. lat = 1 means valid next cycle.
  task automatic do_op32(input int sel, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, output logic [31:0] q,
                         output logic [31:0] r, output logic dz, output int lat);
    signed_op = sgn;
    dividend  = a;
    divisor   = b;
    rv32[sel] = 1'b1;
    @(posedge clk); #1;
    rv32 = 2'b00;
    lat = 1;
    while (((sel == 1) ? resp_valid1 : resp_valid0) == 1'b0 && lat < LIMIT) begin
      @(posedge clk); #1;
      lat++;
    end
    total_cnt++;
    if (lat >= LIMIT) $display("FAIL timeout32 sel=%0d a=%h b=%h: no resp_valid within %0d cycles", sel, a, b, LIMIT);
    else pass_cnt++;
    q  = (sel == 1) ? q1 : q0;
    r  = (sel == 1) ? r1 : r0;
    dz = (sel == 1) ? dz1 : dz0;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  task automatic do_op64(input logic sgn, input logic [63:0] a, input logic [63:0] b,
                         output logic [63:0] q, output logic [63:0] r);
    int lat;
    sop64 = sgn;
    a64   = a;
    b64   = b;
    rv64  = 1'b1;
    @(posedge clk); #1;
    rv64 = 1'b0;
    lat = 1;
    while (!resp_valid64 && lat < LIMIT) begin
      @(posedge clk); #1;
      lat++;
    end
    total_cnt++;
    if (lat >= LIMIT) $display("FAIL timeout64 a=%h b=%h: no resp_valid", a, b);
    else pass_cnt++;
    q = q64;
    r = r64;
    rr64 = 1'b1;
    @(posedge clk); #1;
    rr64 = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total_cnt++;
    if ({req_ready0, resp_valid0, q0, r0, dz0} !== {1'b1, 1'b0, 32'd0, 32'd0, 1'b0})
      $display("FAIL reset_values: rdy=%b vld=%b q=%h r=%h dz=%b, want rdy=1 vld=0 q=0 r=0 dz=0",
               req_ready0, resp_valid0, q0, r0, dz0);
    else pass_cnt++;
    total_cnt++;
    if ({req_ready1, resp_valid1, req_ready64, resp_valid64} !== 4'b1010)
      $display("FAIL reset_ready: got %b want 1010",
               {req_ready1, resp_valid1, req_ready64, resp_valid64});
    else pass_cnt++;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_op;
    bit seen;
    signed_op = 1'b0; dividend = 32'd100; divisor = 32'd7;
    rv32[0] = 1'b1;
    @(posedge clk); #1;
    rv32 = 2'b00;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    total_cnt++;
    if ({req_ready0, resp_valid0, q0, r0} !== {1'b1, 1'b0, 32'd0, 32'd0})
      $display("FAIL reset_mid_op: rdy=%b vld=%b q=%h r=%h, want 1 0 0 0", req_ready0, resp_valid0, q0, r0);
    else pass_cnt++;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (resp_valid0) seen = 1'b1;
    end
    total_cnt++;
    if (seen !== 1'b0) $display("FAIL reset_stale_resp: resp_valid seen=%b want 0", seen);
    else pass_cnt++;
  endtask

  task automatic test_unsigned_et0;
    logic [31:0] q, r; logic dz; int lat;
    do_op32(0, 1'b0, 32'd100, 32'd7, q, r, dz, lat);
    total_cnt++;
    if ({q, r, dz} !== {32'd14, 32'd2, 1'b0})
      $display("FAIL u100_7: q=%0d r=%0d dz=%b, want q=14 r=2 dz=0", q, r, dz);
    else pass_cnt++;
    total_cnt++;
    if (lat !== 34) $display("FAIL u100_7_latency: got %0d want 34", lat);
    else pass_cnt++;
  endtask

  task automatic test_signed;
    logic [31:0] q, r; logic dz; int lat;
    do_op32(1, 1'b1, 32'hFFFF_FFF9, 32'd2, q, r, dz, lat);
    total_cnt++;
    if ({q, r} !== {32'hFFFF_FFFD, 32'hFFFF_FFFF})
      $display("FAIL s_m7_2: q=%h r=%h, want q=fffffffd r=ffffffff", q, r);
    else pass_cnt++;
    do_op32(0, 1'b1, 32'd7, 32'hFFFF_FFFE, q, r, dz, lat);
    total_cnt++;
    if ({q, r} !== {32'hFFFF_FFFD, 32'd1})
      $display("FAIL s_7_m2: q=%h r=%h, want q=fffffffd r=00000001", q, r);
    else pass_cnt++;
  endtask

  task automatic test_div_zero;
    logic [31:0] q, r; logic dz; int lat;
    do_op32(0, 1'b0, 32'h1234_5678, 32'd0, q, r, dz, lat);
    total_cnt++;
    if ({q, r, dz} !== {32'hFFFF_FFFF, 32'h1234_5678, 1'b1})
      $display("FAIL div_zero: q=%h r=%h dz=%b, want ffffffff 12345678 1", q, r, dz);
    else pass_cnt++;
    total_cnt++;
    if (lat !== 1) $display("FAIL div_zero_latency: got %0d want 1", lat);
    else pass_cnt++;
  endtask

  task automatic test_overflow;
    logic [31:0] q, r; logic dz; int lat;
    do_op32(1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, q, r, dz, lat);
    total_cnt++;
    if ({q, r, dz} !== {32'h8000_0000, 32'd0, 1'b0})
      $display("FAIL overflow: q=%h r=%h dz=%b, want 80000000 0 0", q, r, dz);
    else pass_cnt++;
  endtask

  task automatic test_early_term;
    logic [31:0] q, r; logic dz; int lat;
    do_op32(1, 1'b0, 32'd5, 32'd3, q, r, dz, lat);
    total_cnt++;
    if ({q, r} !== {32'd1, 32'd2}) $display("FAIL et_5_3: q=%0d r=%0d, want 1 2", q, r);
    else pass_cnt++;
    total_cnt++;
    if (lat !== 5) $display("FAIL et_5_3_latency: got %0d want 5", lat);
    else pass_cnt++;
    do_op32(1, 1'b0, 32'd0, 32'd7, q, r, dz, lat);
    total_cnt++;
    if ({q, r, dz} !== {32'd0, 32'd0, 1'b0}) $display("FAIL et_zero: q=%h r=%h dz=%b, want 0 0 0", q, r, dz);
    else pass_cnt++;
    total_cnt++;
    if (lat !== 2) $display("FAIL et_zero_latency: got %0d want 2", lat);
    else pass_cnt++;
    do_op32(1, 1'b0, 32'h8000_0000, 32'd3, q, r, dz, lat);
    total_cnt++;
    if ({q, r} !== {32'h2AAA_AAAA, 32'd2}) $display("FAIL et_full: q=%h r=%h, want 2aaaaaaa 2", q, r);
    else pass_cnt++;
    total_cnt++;
    if (lat !== 34) $display("FAIL et_full_latency: got %0d want 34", lat);
    else pass_cnt++;
  endtask

  task automatic test_cancel;
    logic [31:0] q, r; logic dz; int lat; bit seen;
    signed_op = 1'b0; dividend = 32'd1000; divisor = 32'd3;
    rv32[0] = 1'b1;
    @(posedge clk); #1;
    rv32 = 2'b00;
    repeat (9) @(posedge clk);
    #1 cancel = 1'b1;
    @(posedge clk); #1;
    cancel = 1'b0;
    total_cnt++;
    if ({req_ready0, resp_valid0, q0} !== {1'b1, 1'b0, 32'd0})
      $display("FAIL cancel_calc: rdy=%b vld=%b q=%h, want 1 0 0", req_ready0, resp_valid0, q0);
    else pass_cnt++;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (resp_valid0) seen = 1'b1;
    end
    total_cnt++;
    if (seen !== 1'b0) $display("FAIL cancel_stale_resp: resp_valid seen=%b want 0", seen);
    else pass_cnt++;
    // cancel together with a request: the request must be dropped
    dividend = 32'd9; divisor = 32'd0;
    rv32[0] = 1'b1; cancel = 1'b1;
    @(posedge clk); #1;
    rv32 = 2'b00; cancel = 1'b0;
    total_cnt++;
    if ({req_ready0, resp_valid0} !== 2'b10)
      $display("FAIL cancel_vs_accept: rdy=%b vld=%b, want 1 0", req_ready0, resp_valid0);
    else pass_cnt++;
    do_op32(0, 1'b0, 32'd6, 32'd4, q, r, dz, lat);
    total_cnt++;
    if ({q, r, dz} !== {32'd1, 32'd2, 1'b0}) $display("FAIL after_cancel_6_4: q=%0d r=%0d dz=%b, want 1 2 0", q, r, dz);
    else pass_cnt++;
  endtask

  task automatic test_hold;
    int lat;
    signed_op = 1'b0; dividend = 32'd50; divisor = 32'd6;
    rv32[0] = 1'b1;
    @(posedge clk); #1;
    rv32 = 2'b00;
    lat = 1;
    while (!resp_valid0 && lat < LIMIT) begin
      @(posedge clk); #1;
      lat++;
    end
    total_cnt++;
    if (lat >= LIMIT) $display("FAIL hold_timeout: no resp_valid within %0d cycles", LIMIT);
    else pass_cnt++;
    repeat (5) begin
      total_cnt++;
      if ({resp_valid0, req_ready0, q0, r0} !== {1'b1, 1'b0, 32'd8, 32'd2})
        $display("FAIL hold_stable: vld=%b rdy=%b q=%0d r=%0d, want 1 0 8 2", resp_valid0, req_ready0, q0, r0);
      else pass_cnt++;
      @(posedge clk); #1;
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    total_cnt++;
    if ({resp_valid0, req_ready0, q0, r0} !== {1'b0, 1'b1, 32'd0, 32'd0})
      $display("FAIL hold_release: vld=%b rdy=%b q=%h r=%h, want 0 1 0 0", resp_valid0, req_ready0, q0, r0);
    else pass_cnt++;
  endtask

  task automatic test_wide;
    logic [63:0] a, b, q, r, eq, er;
    logic sgn;
    for (int n = 0; n < 100; n++) begin
      sgn = n[0];
      a = {$urandom(), $urandom()};
      b = {$urandom(), $urandom()};
      if ($urandom_range(0, 1) == 1) a = a >> $urandom_range(0, 63);
      b = b >> $urandom_range(0, 63);
      if (b == 64'd0) b = 64'd1;
      if (sgn && a == 64'h8000_0000_0000_0000 && b == '1) b = 64'd2;
      if (sgn) begin
        eq = $signed(a) / $signed(b);
        er = $signed(a) % $signed(b);
      end else begin
        eq = a / b;
        er = a % b;
      end
      do_op64(sgn, a, b, q, r);
      total_cnt++;
      if (q !== eq) $display("FAIL wide_quotient s=%b a=%h b=%h: got %h want %h", sgn, a, b, q, eq);
      else pass_cnt++;
      total_cnt++;
      if (r !== er) $display("FAIL wide_remainder s=%b a=%h b=%h: got %h want %h", sgn, a, b, r, er);
      else pass_cnt++;
    end
  endtask

  initial begin
    rst = 1'b1; rv32 = 2'b00; signed_op = 1'b0; dividend = '0; divisor = '0;
    cancel = 1'b0; resp_ready = 1'b0;
    rv64 = 1'b0; sop64 = 1'b0; rr64 = 1'b0; a64 = '0; b64 = '0;
    test_reset();
    test_unsigned_et0();
    test_signed();
    test_div_zero();
    test_overflow();
    test_early_term();
    test_cancel();
    test_hold();
    test_reset_mid_op();
    test_wide();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
